q_mult: RTL and testbench

Signed fixed-point multiplier used throughout the dense-layer datapath. Each neuron tap multiplies an activation by a weight, and the scaled sum is multiplied by `weight_scale` (1/256). It takes two N-bit signed Q-format operands and produces one registered N-bit result in the same Q format, with saturation and an overflow flag. It is fully pipelined: a new operand pair is accepted every cycle, and there is no handshake.

---
 rtl/q_mult_pkg.sv | 20 ++
 rtl/q_sat.sv | 35 +++
 rtl/q_mult.sv | 65 ++++++
 tb/tb_q_mult.sv | 134 +++++++++++++
 4 files changed

// File: rtl/q_mult_pkg.sv
// rtl/q_mult_pkg.sv - shared constants for the signed fixed-point multiplier
//
// Purpose: default word geometry, saturation limits and Q16.16 constants
//          used by q_mult and the dense-layer datapath.
// Contents:
//   QM_N, QM_Q            default total / fractional bit counts
//   MAX_POS, MIN_NEG      saturation limits for the default word width
//   ONE, WEIGHT_SCALE     Q16.16 encodings of 1.0 and 1/256
package q_mult_pkg;

  localparam int QM_N = 32;
  localparam int QM_Q = 16;

  localparam logic [QM_N-1:0] MAX_POS = {1'b0, {(QM_N-1){1'b1}}};
  localparam logic [QM_N-1:0] MIN_NEG = {1'b1, {(QM_N-1){1'b0}}};

  localparam logic [31:0] ONE          = 32'h0001_0000;
  localparam logic [31:0] WEIGHT_SCALE = 32'h0000_0100;

endpackage

// File: rtl/q_sat.sv
// rtl/q_sat.sv - combinational 2N-bit to N-bit signed saturation
//
// Purpose: clamp a wide signed value into the N-bit two's-complement range.
// Ports:
//   i_val  in  [2N-1:0]  wide signed value
//   o_val  out [N-1:0]   clamped value
//   o_ovf  out           1 when clamping changed the value
module q_sat
  import q_mult_pkg::*;
#(
  parameter int N = QM_N
) (
  input  logic signed [2*N-1:0] i_val,
  output logic signed [N-1:0]   o_val,
  output logic                  o_ovf
);

  // The value fits in N bits exactly when every bit from the N-bit sign
  // position upward is a copy of the wide sign bit.
  logic [N:0] w_hi;
  logic       w_fits;

  assign w_hi   = i_val[2*N-1:N-1];
  assign w_fits = (&w_hi) | ~(|w_hi);

  always_comb begin
    o_val = i_val[N-1:0];
    o_ovf = 1'b0;
    if (!w_fits) begin
      o_ovf = 1'b1;
      o_val = i_val[2*N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end

endmodule

// File: rtl/q_mult.sv
// rtl/q_mult.sv - pipelined signed Q-format multiplier with saturation
//
// Purpose: q_result = sat((a * b) >>> Q), registered, one result per cycle.
// Build option: QMULT_ROUND_EN adds 2^(Q-1) before the shift (round to
//               nearest, halves toward +inf); undefined gives floor.
// Ports:
//   clk       in            rising-edge clock
//   rst       in            asynchronous active-high reset
//   a, b      in  [N-1:0]   signed Q-format operands
//   q_result  out [N-1:0]   registered saturated product
//   overflow  out           registered, 1 when q_result was saturated
module q_mult
  import q_mult_pkg::*;
#(
  parameter int N = QM_N,
  parameter int Q = QM_Q
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] q_result,
  output logic                overflow
);

  logic signed [2*N-1:0] w_a_ext;
  logic signed [2*N-1:0] w_b_ext;
  logic signed [2*N-1:0] w_prod;
  logic signed [2*N-1:0] w_pre;
  logic signed [2*N-1:0] w_shift;
  logic signed [N-1:0]   w_sat;
  logic                  w_ovf;

  // Operands are sign-extended to 2N so the product is exact at 2N bits.
  assign w_a_ext = {{N{a[N-1]}}, a};
  assign w_b_ext = {{N{b[N-1]}}, b};
  assign w_prod  = w_a_ext * w_b_ext;

`ifdef QMULT_ROUND_EN
  // |P| never exceeds 2^(2N-2), so adding the half-LSB cannot wrap.
  localparam logic signed [2*N-1:0] ROUND_K = (2*N)'(1) <<< (Q-1);
  assign w_pre = w_prod + ROUND_K;
`else
  assign w_pre = w_prod;
`endif

  assign w_shift = w_pre >>> Q;

  q_sat #(.N(N)) u_sat (
    .i_val (w_shift),
    .o_val (w_sat),
    .o_ovf (w_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_result <= '0;
      overflow <= 1'b0;
    end else begin
      q_result <= w_sat;
      overflow <= w_ovf;
    end
  end

endmodule

// File: tb/tb_q_mult.sv
// tb/tb_q_mult.sv - self-checking bench for q_mult (N=32, Q=16)
module tb_q_mult;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_q;
    logic        exp_ovf;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] q_result;
  logic        overflow;

  int checks;
  int errors;

  vec_t vecs[16];

  q_mult #(.N(32), .Q(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .q_result (q_result),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [31:0] eq, input logic eo);
    check({name, ".q"}, q_result, eq);
    check({name, ".ovf"}, {31'd0, overflow}, {31'd0, eo});
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1'b0};
    vecs[1]  = '{32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000, 1'b0};
    vecs[2]  = '{32'h0100_0000, 32'h0000_0100, 32'h0001_0000, 1'b0};
    vecs[3]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1};
    vecs[4]  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b1};
`ifdef QMULT_ROUND_EN
    vecs[5]  = '{32'h0000_0001, 32'h0000_8000, 32'h0000_0001, 1'b0};
    vecs[6]  = '{32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_0000, 1'b0};
`else
    vecs[5]  = '{32'h0000_0001, 32'h0000_8000, 32'h0000_0000, 1'b0};
    vecs[6]  = '{32'hFFFF_FFFF, 32'h0000_8000, 32'hFFFF_FFFF, 1'b0};
`endif
    vecs[7]  = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[9]  = '{32'hFFFF_0000, 32'hFFFF_0000, 32'h0001_0000, 1'b0};
    vecs[10] = '{32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0};
    vecs[11] = '{32'h7FFF_FFFF, 32'h0001_0000, 32'h7FFF_FFFF, 1'b0};
    vecs[12] = '{32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[13] = '{32'h0000_8000, 32'h0000_8000, 32'h0000_4000, 1'b0};
    vecs[14] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0};
    vecs[15] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};

    // Reset held across edges with live operands: outputs stay 0.
    rst = 1'b1;
    a   = 32'h7FFF_FFFF;
    b   = 32'h7FFF_FFFF;
    #1;
    check_out("reset_async", 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_held", 32'h0, 1'b0);

    // Release between edges; first result only after the next edge.
    @(negedge clk);
    rst = 1'b0;
    a   = vecs[0].a;
    b   = vecs[0].b;
    #1;
    check_out("reset_release_hold", 32'h0, 1'b0);

    // Back-to-back streaming: one new pair per cycle, results in order.
    // Just before each edge the previous result must still be held
    // even though the operands have already moved on.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_ovf);
      @(negedge clk);
      a = vecs[(i + 1) % 16].a;
      b = vecs[(i + 1) % 16].b;
      #3;
      check_out($sformatf("hold%0d", i), vecs[i].exp_q, vecs[i].exp_ovf);
    end

    // Mid-stream reset between edges discards the in-flight result.
    @(negedge clk);
    a = vecs[3].a;
    b = vecs[3].b;
    @(posedge clk);
    #1;
    check_out("pre_rst_sat", 32'h7FFF_FFFF, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_out("mid_rst_async", 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check_out("mid_rst_edge", 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    a   = vecs[1].a;
    b   = vecs[1].b;
    #1;
    check_out("mid_rst_release", 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check_out("post_rst_first", vecs[1].exp_q, vecs[1].exp_ovf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
